// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg : shared constants, helpers and state encoding for the FFT feeder
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Width of the pair index / sample counter: log2(N/2), never below one bit.
  function automatic int idx_width(input int points);
    int w;
    w = clog2(points / 2);
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PAIR = 1'b1
  } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/fft_dif_pair_feeder_if.sv
// ---------------------------------------------------------------------------
// fft_dif_pair_feeder_if : sample-in / butterfly-pair-out handshake bundle
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface fft_dif_pair_feeder_if #(
  parameter int DataWidth = fft_pkg::DATA_WIDTH_DEFAULT,
  parameter int N         = 16
);

  localparam int IdxW = fft_pkg::idx_width(N);

  logic                 in_valid;
  logic                 in_ready;
  logic [DataWidth-1:0] in_re;
  logic [DataWidth-1:0] in_im;
  logic                 pair_valid;
  logic                 pair_ready;
  logic [DataWidth-1:0] X0_Re;
  logic [DataWidth-1:0] X0_Im;
  logic [DataWidth-1:0] X1_Re;
  logic [DataWidth-1:0] X1_Im;
  logic [IdxW-1:0]      pair_idx;
  logic                 pair_last;

  // Feeder side: consumes samples, produces pairs.
  modport master (
    input  in_valid, in_re, in_im, pair_ready,
    output in_ready, pair_valid, X0_Re, X0_Im, X1_Re, X1_Im, pair_idx, pair_last
  );

  // Environment side: sample front-end plus butterfly.
  modport slave (
    output in_valid, in_re, in_im, pair_ready,
    input  in_ready, pair_valid, X0_Re, X0_Im, X1_Re, X1_Im, pair_idx, pair_last
  );

endinterface

`default_nettype wire

// File: rtl/fft_half_frame_buf.sv
// ---------------------------------------------------------------------------
// fft_half_frame_buf : half-frame sample store, sync write, async read
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fft_half_frame_buf
  import fft_pkg::*;
#(
  parameter int Depth = 8,
  parameter int Width = 32
) (
  input  logic                                   clk,
  input  logic                                   we,
  input  logic [((Depth > 1) ? clog2(Depth) : 1)-1:0] waddr,
  input  logic [Width-1:0]                       wdata,
  input  logic [((Depth > 1) ? clog2(Depth) : 1)-1:0] raddr,
  output logic [Width-1:0]                       rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fft_dif_pair_feeder.sv
// ---------------------------------------------------------------------------
// fft_dif_pair_feeder : buffers half a frame and emits DIF pairs (x[k], x[k+N/2])
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fft_dif_pair_feeder
  import fft_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH_DEFAULT,
  parameter int N         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_dif_pair_feeder_if.master bus
);

  localparam int Half  = N / 2;
  localparam int IdxW  = idx_width(N);
  localparam int Width = 2 * DataWidth;

  feeder_state_e        state;
  logic [IdxW-1:0]      cnt;
  logic                 cnt_last;
  logic                 accept;
  logic                 in_ready;
  logic [Width-1:0]     rd_data;

  logic                 pair_valid;
  logic [DataWidth-1:0] x0_re;
  logic [DataWidth-1:0] x0_im;
  logic [DataWidth-1:0] x1_re;
  logic [DataWidth-1:0] x1_im;
  logic [IdxW-1:0]      pair_idx;
  logic                 pair_last;

  // FILL never touches the output register, so it can always take a sample.
  assign in_ready = (state == FILL) || !pair_valid || bus.pair_ready;
  assign accept   = bus.in_valid && in_ready;
  assign cnt_last = (cnt == IdxW'(Half - 1));

  fft_half_frame_buf #(
    .Depth (Half),
    .Width (Width)
  ) u_buf (
    .clk   (clk),
    .we    (accept && (state == FILL)),
    .waddr (cnt),
    .wdata ({bus.in_re, bus.in_im}),
    .raddr (cnt),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= '0;
      pair_valid <= 1'b0;
      x0_re      <= '0;
      x0_im      <= '0;
      x1_re      <= '0;
      x1_im      <= '0;
      pair_idx   <= '0;
      pair_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (cnt_last) begin
          cnt   <= '0;
          state <= (state == FILL) ? PAIR : FILL;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (accept && (state == PAIR)) begin
        x0_re      <= rd_data[Width-1:DataWidth];
        x0_im      <= rd_data[DataWidth-1:0];
        x1_re      <= bus.in_re;
        x1_im      <= bus.in_im;
        pair_idx   <= cnt;
        pair_last  <= cnt_last;
        pair_valid <= 1'b1;
      end else if (pair_valid && bus.pair_ready) begin
        pair_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.pair_valid = pair_valid;
  assign bus.X0_Re      = x0_re;
  assign bus.X0_Im      = x0_im;
  assign bus.X1_Re      = x1_re;
  assign bus.X1_Im      = x1_im;
  assign bus.pair_idx   = pair_idx;
  assign bus.pair_last  = pair_last;

endmodule

`default_nettype wire

// File: tb/tb_fft_dif_pair_feeder.sv
// ---------------------------------------------------------------------------
// tb_fft_dif_pair_feeder : directed and randomised checks for N=2, 8 and 16
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fft_dif_pair_feeder;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_dif_pair_feeder_if #(.DataWidth(16), .N(2))  b2 ();
  fft_dif_pair_feeder_if #(.DataWidth(16), .N(8))  b8 ();
  fft_dif_pair_feeder_if #(.DataWidth(16), .N(16)) b16 ();

  fft_dif_pair_feeder #(.DataWidth(16), .N(2))  u_dut2  (.clk(clk), .rst(rst), .bus(b2));
  fft_dif_pair_feeder #(.DataWidth(16), .N(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));
  fft_dif_pair_feeder #(.DataWidth(16), .N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- N=8 output monitor ----------------
  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  idx;
    logic        last;
  } p8_t;
  p8_t got8[$];

  always @(negedge clk) begin
    if (!rst && b8.pair_valid && b8.pair_ready)
      got8.push_back({b8.X0_Re, b8.X0_Im, b8.X1_Re, b8.X1_Im, b8.pair_idx, b8.pair_last});
  end

  task automatic check_got8(input int a0, input int cnt);
    p8_t         p;
    logic [15:0] x0, x1;
    for (int j = 0; j < cnt; j++) begin
      if (got8.size() == 0) begin
        check("n8_pair_count", got8.size(), cnt - j);
        return;
      end
      p  = got8.pop_front();
      x0 = 16'(a0 + j);
      x1 = 16'(a0 + j + 4);
      check("n8_pair_data", p.d, {x0, -x0, x1, -x1});
      check("n8_pair_idx", p.idx, j);
      check("n8_pair_last", p.last, (j == 3));
    end
  endtask

  task automatic push8(input int re);
    logic acc;
    int   t;
    t = 0;
    b8.in_valid = 1'b1;
    b8.in_re    = 16'(re);
    b8.in_im    = 16'(-re);
    forever begin
      @(negedge clk);
      acc = b8.in_ready;
      @(posedge clk); #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        check("n8_push_timeout", b8.in_ready, 1);
        break;
      end
    end
  endtask

  task automatic wait8(input int idx);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(b8.pair_valid && b8.pair_idx == 2'(idx)) && t < 100);
    if (t >= 100) check("n8_wait_timeout", b8.pair_valid, 1);
  endtask

  // ---------------- N=16 reference pairing model ----------------
  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  idx;
    logic        last;
  } p16_t;
  p16_t        exp16[$];
  logic [31:0] half16 [8];
  int          pos16    = 0;
  int          n16_pairs = 0;

  always @(negedge clk) begin
    p16_t e;
    if (rst) begin
      pos16 = 0;
      exp16.delete();
    end else begin
      if (b16.in_valid && b16.in_ready) begin
        if (pos16 < 8) half16[pos16] = {b16.in_re, b16.in_im};
        else exp16.push_back({half16[pos16-8], b16.in_re, b16.in_im, 3'(pos16 - 8), (pos16 == 15)});
        pos16 = (pos16 + 1) % 16;
      end
      if (b16.pair_valid && b16.pair_ready) begin
        if (exp16.size() == 0) begin
          check("n16_unexpected_pair", b16.pair_valid, 0);
        end else begin
          e = exp16.pop_front();
          check("n16_pair_data", {b16.X0_Re, b16.X0_Im, b16.X1_Re, b16.X1_Im}, e.d);
          check("n16_pair_tag", {b16.pair_idx, b16.pair_last}, {e.idx, e.last});
          n16_pairs++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b2.in_valid = 0;  b2.in_re = 0;  b2.in_im = 0;  b2.pair_ready = 0;
    b8.in_valid = 0;  b8.in_re = 0;  b8.in_im = 0;  b8.pair_ready = 0;
    b16.in_valid = 0; b16.in_re = 0; b16.in_im = 0; b16.pair_ready = 0;

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_pair_valid", b8.pair_valid, 0);
    check("rst_x0_re", b8.X0_Re, 0);
    check("rst_x1_im", b8.X1_Im, 0);
    check("rst_pair_idx", b8.pair_idx, 0);
    check("rst_pair_last", b8.pair_last, 0);
    check("rst_in_ready", b8.in_ready, 1);
    check("rst_n2_pair_valid", b2.pair_valid, 0);

    // N=2: one-entry buffer, states alternate every sample
    @(posedge clk); #1;
    b2.pair_ready = 1; b2.in_valid = 1; b2.in_re = 16'd100; b2.in_im = 0;
    @(posedge clk); #1;
    check("n2_fill_no_pair", b2.pair_valid, 0);
    b2.in_re = 16'd700;
    @(posedge clk); #1;
    b2.in_valid = 0;
    check("n2_pair_valid", b2.pair_valid, 1);
    check("n2_x0_re", b2.X0_Re, 16'd100);
    check("n2_x1_re", b2.X1_Re, 16'd700);
    check("n2_im", {b2.X0_Im, b2.X1_Im}, 0);
    check("n2_idx_last", {b2.pair_idx, b2.pair_last}, 2'b01);
    check("n2_bfly_y0", 16'(b2.X0_Re + b2.X1_Re), 16'd800);
    check("n2_bfly_y1", 16'(b2.X0_Re - b2.X1_Re), 16'hFDA8);
    @(posedge clk); #1;
    check("n2_taken", b2.pair_valid, 0);

    // N=8 continuous streaming, two back-to-back frames
    b8.pair_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      b8.in_valid = 1; b8.in_re = 16'(i); b8.in_im = 16'(-i);
      @(negedge clk);
      check("n8c_in_ready", b8.in_ready, 1);
      @(posedge clk); #1;
    end
    b8.in_valid = 0;
    repeat (3) @(posedge clk); #1;
    check_got8(1, 4);
    check_got8(9, 4);
    check("n8c_empty", got8.size(), 0);

    // N=8 stall inside PAIR
    b8.pair_ready = 0;
    fork
      begin
        for (int i = 1; i <= 8; i++) push8(i);
        b8.in_valid = 0;
      end
      begin
        wait8(0);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("n8s_in_ready", b8.in_ready, 0);
          check("n8s_frozen", {b8.X0_Re, b8.X1_Re, b8.X1_Im}, {16'd1, 16'd5, -16'd5});
        end
        @(posedge clk); #1;
        b8.pair_ready = 1;
      end
    join
    repeat (4) @(posedge clk); #1;
    check_got8(1, 4);
    check("n8s_empty", got8.size(), 0);

    // N=8 last pair held across PAIR->FILL
    b8.pair_ready = 1;
    fork
      begin
        for (int i = 1; i <= 16; i++) push8(i);
        b8.in_valid = 0;
      end
      begin
        wait8(2);
        @(posedge clk); #1;
        b8.pair_ready = 0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("n8b_held", {b8.pair_valid, b8.X0_Re, b8.X1_Re, b8.pair_last}, {1'b1, 16'd4, 16'd8, 1'b1});
        end
        @(negedge clk);
        check("n8b_in_ready", b8.in_ready, 0);
        @(posedge clk); #1;
        b8.pair_ready = 1;
      end
    join
    repeat (4) @(posedge clk); #1;
    check_got8(1, 4);
    check_got8(9, 4);
    check("n8b_empty", got8.size(), 0);

    // N=8 reset mid-frame
    b8.pair_ready = 1;
    for (int i = 1; i <= 6; i++) push8(i);
    b8.in_valid = 0;
    b8.pair_ready = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("n8r_pair_valid", b8.pair_valid, 0);
    check("n8r_x0_re", b8.X0_Re, 0);
    check("n8r_in_ready", b8.in_ready, 1);
    got8.delete();
    @(posedge clk); #1;
    b8.pair_ready = 1;
    for (int i = 10; i <= 17; i++) push8(i);
    b8.in_valid = 0;
    repeat (3) @(posedge clk); #1;
    check_got8(10, 4);
    check("n8r_empty", got8.size(), 0);

    // N=16 random valid/ready, 50 frames
    begin
      int   i, t;
      logic acc;
      i = 0; t = 0;
      while (i < 800 && t < 20000) begin
        b16.in_valid   = ($urandom_range(0, 3) != 0);
        b16.in_re      = 16'(i * 37 + 5);
        b16.in_im      = 16'(i * 11) ^ 16'h5a5a;
        b16.pair_ready = ($urandom_range(0, 1) != 0);
        @(negedge clk);
        acc = b16.in_valid && b16.in_ready;
        @(posedge clk); #1;
        if (acc) i++;
        t++;
      end
      check("n16_all_sent", i, 800);
      b16.in_valid   = 0;
      b16.pair_ready = 1;
      t = 0;
      while ((exp16.size() != 0 || b16.pair_valid) && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      repeat (2) @(posedge clk); #1;
      check("n16_drained", exp16.size(), 0);
      check("n16_pair_total", n16_pairs, 400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_dif_pair_feeder.md
Name: fft_dif_pair_feeder

Overview:
- Streaming source for the radix-2 butterfly input port (X0_Re/X0_Im/X1_Re/X1_Im).
- Accepts one complex sample per handshake, in natural order, N samples per frame.
- Buffers the first half-frame, then emits the decimation-in-frequency first-stage pairs (x[k], x[k+N/2]), k = 0..N/2-1, in registered form with valid/ready.
- Sits between the sample front-end and Butterfly_Radix2 in the FFT datapath.

Parameters:
- DataWidth, 16, width of each real/imag component (two's complement, passed through unmodified).
- N, 16, FFT points per frame; power of two, N >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid && in_ready.
- in_re  in  DataWidth  input sample real part.
- in_im  in  DataWidth  input sample imaginary part.
- pair_valid  out  1  output pair valid.
- pair_ready  in  1  downstream accepts the pair when pair_valid && pair_ready.
- X0_Re  out  DataWidth  real part of x[k].
- X0_Im  out  DataWidth  imaginary part of x[k].
- X1_Re  out  DataWidth  real part of x[k+N/2].
- X1_Im  out  DataWidth  imaginary part of x[k+N/2].
- pair_idx  out  max(1,log2(N/2))  k; the twiddle index for the stage.
- pair_last  out  1  high with the pair where k = N/2-1.

Behaviour:
- Reset: one clock with rst=1. Afterwards pair_valid=0, X0_*/X1_*=0, pair_idx=0, pair_last=0, state=FILL, sample counter cnt=0, in_ready=1. Buffer contents are don't-care.
- State FILL:
  - in_ready=1 unconditionally.
  - Each accepted sample is written to buf[cnt], and cnt increments.
  - On accepting cnt=N/2-1: cnt wraps to 0 and the state moves to PAIR.
  - The output register is untouched, so a pending pair from the previous frame stays valid until it is taken.
- State PAIR:
  - in_ready = !pair_valid || pair_ready (one-deep output register, no skid).
  - On accept: X0 <= buf[cnt], X1 <= {in_re,in_im}, pair_idx <= cnt, pair_last <= (cnt==N/2-1), pair_valid <= 1, cnt increments.
  - On accepting cnt=N/2-1: cnt wraps to 0 and the state moves to FILL.
- Latency: a pair appears the cycle after its second-half sample is accepted.
- Output handshake:
  - When pair_valid && pair_ready and no new accept occurs in the same cycle, pair_valid goes to 0.
  - A simultaneous take and load replaces the pair with no bubble. Sustained throughput is 1 sample/cycle.
  - X0_*/X1_*/pair_idx/pair_last hold stable while pair_valid && !pair_ready.
- Buffer: N/2 x 2*DataWidth, one write port, asynchronous read.
  - In FILL, buf[cnt] may be overwritten in the same cycle that a pending pair is still held; this is safe because values are copied into the output register at load time.
- N=2: buf has one entry and states alternate on every accepted sample.
- Reset mid-frame: the partial frame is discarded, the pending pair is dropped, and the next accepted sample is x[0] of a new frame.
- No arithmetic is performed; widths are preserved bit-exact.

Decomposition:
- Shared package fft_pkg holds:
  - DataWidth default.
  - clog2 helper.
  - Feeder state encoding (FILL=0, PAIR=1).
- Single sub-module fft_half_frame_buf (parameters Depth=N/2, Width=2*DataWidth): synchronous write, asynchronous read, no reset.
- All other logic (counter, FSM, output register) stays in the top module.

Test Plan:
- N=2, samples (100,0) then (700,0), pair_ready=1 -> one cycle later: pair_valid=1, X0_Re=100, X1_Re=700, X0_Im=X1_Im=0, pair_idx=0, pair_last=1. Feeding into Butterfly_Radix2 gives Y0_Re=800, Y1_Re=-600 (16'hFDA8).
- N=8, samples re=1..8, im=-re, continuous valid, pair_ready=1 -> pairs (1,5),(2,6),(3,7),(4,8) with im negated, pair_idx 0..3, pair_last on the 4th only. in_ready stays 1 throughout; next frame follows with no gap.
- N=8, pair_ready held 0 during PAIR -> first pair loads, in_ready drops to 0 and the outputs stay frozen. Releasing pair_ready resumes at 1 pair/cycle with no lost or duplicated pair.
- N=8, pair_ready=0 across the PAIR->FILL boundary -> the last pair (4,8) is held while FILL accepts samples 9..12. On release, pair (4,8) is delivered, then the frame-2 pairs are correct.
- N=8, rst asserted after 6 samples -> pair_valid=0 next cycle. A following clean frame of 10..17 yields pairs (10,14)..(13,17) with pair_idx starting at 0.
- Random in_valid/pair_ready toggling, N=16, 50 frames -> scoreboard matches every pair against the reference pairing; zero drops or duplicates.
